// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler and PWM counter,
// per-channel OFF / ON / BLINK / ONESHOT modes programmed through a write-only port.

module led_pattern_chan #(
    parameter int PERIOD_W = 12,
    parameter int PWM_W    = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_tick,
    input  logic                i_we,
    input  logic [1:0]          i_mode,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [PWM_W-1:0]    i_duty,
    input  logic [PWM_W-1:0]    i_pwm,
    output logic                o_led
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    mode_t               r_mode, w_mode_nxt;
    logic [PERIOD_W-1:0] r_period, r_phase, w_phase_nxt;
    logic [PERIOD_W-1:0] w_eff, w_per, w_half;
    logic [PWM_W-1:0]    r_duty;
    logic                r_led, w_lit, w_bright, w_last;

    // Period 0 behaves as 1; BLINK needs at least 2 ticks to show both halves.
    assign w_eff    = (r_period == '0) ? PERIOD_W'(1) : r_period;
    assign w_per    = (r_mode == MODE_BLINK && w_eff < PERIOD_W'(2)) ? PERIOD_W'(2) : w_eff;
    assign w_half   = w_per >> 1;
    assign w_last   = (r_phase == w_per - PERIOD_W'(1));
    assign w_bright = (&r_duty) || (i_pwm < r_duty);

    always_comb begin
        w_mode_nxt  = r_mode;
        w_phase_nxt = r_phase;
        w_lit       = 1'b0;
        case (r_mode)
            MODE_ON:      w_lit = w_bright;
            MODE_BLINK:   w_lit = w_bright && (r_phase < w_half);
            MODE_ONESHOT: w_lit = w_bright && (r_phase < w_per);
            default:      w_lit = 1'b0;
        endcase
        // A write in a tick cycle restarts the phase and swallows that tick.
        if (i_we) begin
            w_mode_nxt  = mode_t'(i_mode);
            w_phase_nxt = '0;
        end else if (i_tick) begin
            case (r_mode)
                MODE_BLINK: w_phase_nxt = w_last ? '0 : r_phase + PERIOD_W'(1);
                MODE_ONESHOT: begin
                    if (w_last) begin
                        w_mode_nxt  = MODE_OFF;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + PERIOD_W'(1);
                    end
                end
                default: w_phase_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode   <= MODE_OFF;
            r_phase  <= '0;
            r_period <= '0;
            r_duty   <= '0;
            r_led    <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_lit;
            if (i_we) begin
                r_period <= i_period;
                r_duty   <= i_duty;
            end
        end
    end

    assign o_led = r_led;
endmodule

module led_pattern_gen #(
    parameter  int CLK_HZ   = 16000000,
    parameter  int TICK_HZ  = 1000,
    parameter  int CHANNELS = 4,
    parameter  int PERIOD_W = 12,
    parameter  int PWM_W    = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_we,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [1:0]          i_cfg_mode,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    input  logic [PWM_W-1:0]    i_cfg_duty,
    output logic [CHANNELS-1:0] o_led,
    output logic                o_tick
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = $clog2(DIV);

    logic [PS_W-1:0]  r_presc;
    logic [PWM_W-1:0] r_pwm;
    logic             r_tick;
    logic             w_wrap, w_ch_ok;

    assign w_wrap  = (r_presc == PS_W'(DIV - 1));
    assign w_ch_ok = (32'(i_cfg_ch) < CHANNELS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + PS_W'(1);
            r_pwm   <= r_pwm + PWM_W'(1);
            r_tick  <= w_wrap;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_pattern_chan #(
            .PERIOD_W (PERIOD_W),
            .PWM_W    (PWM_W)
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (r_tick),
            .i_we     (i_cfg_we && w_ch_ok && (i_cfg_ch == CH_W'(i))),
            .i_mode   (i_cfg_mode),
            .i_period (i_cfg_period),
            .i_duty   (i_cfg_duty),
            .i_pwm    (r_pwm),
            .o_led    (o_led[i])
        );
    end

    assign o_tick = r_tick;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: cycle-accurate reference model feeding a scoreboard,
// plus directed run-length checks on the blink, PWM, one-shot and reset behaviour.

module tb_led_pattern_gen;
    localparam int DIV = 10;
    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [1:0] ch = '0;
    logic [1:0] mode = '0;
    logic [3:0] per = '0;
    logic [3:0] duty = '0;
    logic [3:0] led;
    logic       tick;
    logic [2:0] led3;
    logic       tick3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(4), .PERIOD_W(4), .PWM_W(4)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(we), .i_cfg_ch(ch), .i_cfg_mode(mode),
        .i_cfg_period(per), .i_cfg_duty(duty), .o_led(led), .o_tick(tick)
    );

    // Three-channel copy so a channel index beyond the top can be driven.
    led_pattern_gen #(
        .CLK_HZ(1000), .TICK_HZ(100), .CHANNELS(3), .PERIOD_W(4), .PWM_W(4)
    ) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(we), .i_cfg_ch(ch), .i_cfg_mode(mode),
        .i_cfg_period(per), .i_cfg_duty(duty), .o_led(led3), .o_tick(tick3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, stepped on every rising edge; expected outputs are queued.
    int         m_presc, m_pwm;
    int         m_mode[NCH], m_per[NCH], m_duty[NCH], m_ph[NCH];
    bit         m_tick;
    logic [4:0] sb_q[$];

    always @(posedge clk) begin
        logic [3:0] nl;
        bit         nt, bright;
        int         ep, bp;
        if (rst) begin
            m_presc = 0; m_pwm = 0; m_tick = 0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_ph[i] = 0;
            end
            sb_q.push_back(5'b0);
        end else begin
            nl = '0;
            for (int i = 0; i < NCH; i++) begin
                ep = (m_per[i] == 0) ? 1 : m_per[i];
                bp = (ep < 2) ? 2 : ep;
                bright = (m_duty[i] == 15) || (m_pwm < m_duty[i]);
                case (m_mode[i])
                    1: nl[i] = bright;
                    2: nl[i] = bright && (m_ph[i] < bp / 2);
                    3: nl[i] = bright && (m_ph[i] < ep);
                    default: nl[i] = 1'b0;
                endcase
                if (we && int'(ch) == i) begin
                    m_mode[i] = int'(mode); m_per[i] = int'(per);
                    m_duty[i] = int'(duty); m_ph[i] = 0;
                end else if (m_tick) begin
                    if (m_mode[i] == 2) m_ph[i] = (m_ph[i] == bp - 1) ? 0 : m_ph[i] + 1;
                    else if (m_mode[i] == 3) begin
                        if (m_ph[i] == ep - 1) begin m_mode[i] = 0; m_ph[i] = 0; end
                        else m_ph[i] = m_ph[i] + 1;
                    end
                end
            end
            nt = (m_presc == DIV - 1);
            m_presc = (m_presc + 1) % DIV;
            m_pwm = (m_pwm + 1) % 16;
            m_tick = nt;
            sb_q.push_back({nt, nl});
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_led", 32'(led), 32'(e[3:0]));
            chk("sb_tick", 32'(tick), 32'(e[4]));
        end
    end

    task automatic wr(input logic [1:0] c, input logic [1:0] m, input logic [3:0] p,
                      input logic [3:0] d);
        ch = c; mode = m; per = p; duty = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("wait_tick", 32'(tick), 1);
    endtask

    task automatic runs(input int c, output int hi, output int lo);
        int n = 0;
        while (led[c] !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        while (led[c] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        hi = 0;
        while (led[c] === 1'b1 && hi < 300) begin @(negedge clk); hi++; end
        lo = 0;
        while (led[c] === 1'b0 && lo < 300) begin @(negedge clk); lo++; end
    endtask

    task automatic count_high(input int c, input int cycles, output int hi);
        hi = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (led[c] === 1'b1) hi++;
        end
    endtask

    task automatic first_tick(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 50);
        chk(tag, n, 10);
    endtask

    initial begin
        int hi, lo;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 0);
        chk("rst_tick", 32'(tick), 0);
        rst = 1'b0;
        first_tick("first_tick");
        @(negedge clk);
        chk("tick_width", 32'(tick), 0);
        begin
            int n = 1;
            while (tick !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk("tick_gap", n, 10);
        end

        wr(0, 2, 4, 15);
        runs(0, hi, lo);
        chk("blink4_hi", hi, 20);
        chk("blink4_lo", lo, 20);
        chk("blink4_others", 32'(led[3:1]), 0);
        wr(0, 2, 5, 15);
        runs(0, hi, lo);
        chk("blink5_hi", hi, 20);
        chk("blink5_lo", lo, 30);
        wr(0, 2, 0, 15);
        runs(0, hi, lo);
        chk("blink0_hi", hi, 10);
        chk("blink0_lo", lo, 10);
        wr(0, 0, 0, 0);

        wr(1, 1, 0, 4);
        runs(1, hi, lo);
        chk("pwm4_hi", hi, 4);
        chk("pwm4_lo", lo, 12);
        wr(1, 1, 0, 0);
        @(negedge clk);
        count_high(1, 40, hi);
        chk("pwm0_hi", hi, 0);
        wr(1, 1, 0, 15);
        @(negedge clk);
        count_high(1, 40, hi);
        chk("pwm15_hi", hi, 40);
        wr(1, 0, 0, 0);

        // One-shot written in a tick cycle: lit for exactly 3 full tick periods.
        for (int r = 0; r < 2; r++) begin
            wait_tick();
            wr(2, 3, 3, 15);
            @(negedge clk);
            hi = 0;
            while (led[2] === 1'b1 && hi < 300) begin @(negedge clk); hi++; end
            chk("oneshot_hi", hi, 30);
            count_high(2, 60, hi);
            chk("oneshot_stays_off", hi, 0);
        end

        // Blink restarted by a write landing on a tick while it sits at phase 1.
        wr(0, 2, 4, 15);
        wait_tick();
        @(negedge clk);
        wait_tick();
        wr(0, 2, 4, 15);
        @(negedge clk);
        hi = 0;
        while (led[0] === 1'b1 && hi < 300) begin @(negedge clk); hi++; end
        chk("tick_write_restart", hi, 20);

        wr(0, 0, 0, 0);
        @(negedge clk);
        wr(3, 1, 0, 15);
        @(negedge clk);
        chk("oor_ignored", 32'(led3), 0);
        chk("ch3_on_main", 32'(led[3]), 1);
        wr(2, 1, 0, 15);
        @(negedge clk);
        chk("inrange_led3", 32'(led3), 32'b100);
        wr(2, 0, 0, 0);
        wr(3, 0, 0, 0);

        wr(0, 2, 4, 15);
        wr(2, 3, 3, 15);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_led", 32'(led), 0);
        chk("midrst_tick", 32'(tick), 0);
        rst = 1'b0;
        first_tick("rst_first_tick");
        count_high(0, 40, hi);
        chk("post_rst_ch0_off", hi, 0);
        count_high(2, 40, hi);
        chk("post_rst_ch2_off", hi, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
